// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
package prog_loader_pkg;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned ADDR_W         = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    CHECK  = 3'd5,
`endif
    FINISH = 3'd6,
    ERROR  = 3'd7
  } state_e;

  // Per-state control outputs, registered alongside the state.
  typedef struct packed {
    logic rx_ready;
    logic mem_write;
    logic cpu_reset;
    logic busy;
    logic done;
    logic error;
  } ctrl_t;

  // Output decode for a given state.
  function automatic ctrl_t ctrl_for(state_e s);
    ctrl_t c;
    c           = '0;
    c.cpu_reset = 1'b1;
    case (s)
      LEN_HI, LEN_LO, DATA: begin
        c.rx_ready = 1'b1;
        c.busy     = 1'b1;
      end
      WRITE: begin
        c.mem_write = 1'b1;
        c.busy      = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        c.rx_ready = 1'b1;
        c.busy     = 1'b1;
      end
`endif
      FINISH: begin
        c.done      = 1'b1;
        c.cpu_reset = 1'b0;
      end
      ERROR: c.error = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream and memory-write bus between a host and the program loader.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic              start;
  logic [BYTE_W-1:0] rxData;
  logic              rxValid;
  logic              rxReady;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddress;
  logic [WORD_W-1:0] memWriteData;
  logic              cpuReset;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, rxData, rxValid,
    output rxReady, memWrite, memAddress, memWriteData, cpuReset, busy, done, error
  );

  modport master (
    output start, rxData, rxValid,
    input  rxReady, memWrite, memAddress, memWriteData, cpuReset, busy, done, error
  );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Packs incoming bytes MSB-first into a 32-bit word; flags the 4th byte.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              full_c
);

  logic [LANE_W-1:0] lane;

  // The byte being loaded now completes the word.
  assign full_c = load && (lane == LANE_W'(BYTES_PER_WORD - 1));

  // Shift register and byte-lane counter.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      word <= '0;
      lane <= '0;
    end else if (load) begin
      word <= {word[WORD_W-BYTE_W-1:0], data};
      lane <= lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a length-prefixed byte stream and writes
// big-endian words to memory from BASE_ADDR, holding the CPU in reset until
// the load completes. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       MAX_WORDS = 256
) (
  input logic          clock,
  input logic          reset,
  prog_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e TAIL_ST = CHECK;
`else
  localparam state_e TAIL_ST = FINISH;
`endif

  state_e            state;
  ctrl_t             ctrl;
  logic [CNT_W-1:0]  n_words;
  logic [CNT_W-1:0]  index;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] word;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  logic             fire_c;
  logic             asm_load_c;
  logic             asm_clear_c;
  logic             asm_full_c;
  logic [CNT_W-1:0] n_next_c;
  logic [CNT_W-1:0] index_next_c;

  // Handshake and datapath helpers.
  assign fire_c       = bus.rxValid && ctrl.rx_ready;
  assign asm_load_c   = fire_c && (state == DATA);
  assign asm_clear_c  = (state == IDLE) && bus.start;
  assign n_next_c     = {n_words[CNT_W-1:BYTE_W], bus.rxData};
  assign index_next_c = index + CNT_W'(1);

  word_assembler u_asm (
    .clock  (clock),
    .reset  (reset),
    .load   (asm_load_c),
    .clear  (asm_clear_c),
    .data   (bus.rxData),
    .word   (word),
    .full_c (asm_full_c)
  );

  // Loader FSM with registered control outputs and write address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ctrl    <= ctrl_for(IDLE);
      n_words <= '0;
      index   <= '0;
      addr    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= LEN_HI;
            ctrl    <= ctrl_for(LEN_HI);
            n_words <= '0;
            index   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end

        LEN_HI: begin
          if (fire_c) begin
            n_words <= {bus.rxData, BYTE_W'(0)};
`ifdef LOADER_CHECKSUM_EN
            csum    <= csum ^ bus.rxData;
`endif
            state   <= LEN_LO;
            ctrl    <= ctrl_for(LEN_LO);
          end
        end

        LEN_LO: begin
          if (fire_c) begin
            n_words <= n_next_c;
`ifdef LOADER_CHECKSUM_EN
            csum    <= csum ^ bus.rxData;
`endif
            if (32'(n_next_c) > MAX_WORDS) begin
              state <= ERROR;
              ctrl  <= ctrl_for(ERROR);
            end else if (n_next_c == '0) begin
              state <= TAIL_ST;
              ctrl  <= ctrl_for(TAIL_ST);
            end else begin
              state <= DATA;
              ctrl  <= ctrl_for(DATA);
            end
          end
        end

        DATA: begin
          if (fire_c) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ bus.rxData;
`endif
            if (asm_full_c) begin
              addr  <= BASE_ADDR + (ADDR_W'(index) << LANE_W);
              state <= WRITE;
              ctrl  <= ctrl_for(WRITE);
            end
          end
        end

        WRITE: begin
          index <= index_next_c;
          if (index_next_c < n_words) begin
            state <= DATA;
            ctrl  <= ctrl_for(DATA);
          end else begin
            state <= TAIL_ST;
            ctrl  <= ctrl_for(TAIL_ST);
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (fire_c) begin
            if (bus.rxData == csum) begin
              state <= FINISH;
              ctrl  <= ctrl_for(FINISH);
            end else begin
              state <= ERROR;
              ctrl  <= ctrl_for(ERROR);
            end
          end
        end
`endif

        FINISH, ERROR: ;

        default: begin
          state <= ERROR;
          ctrl  <= ctrl_for(ERROR);
        end
      endcase
    end
  end

  // Drive the bus from registered state.
  assign bus.rxReady      = ctrl.rx_ready;
  assign bus.memWrite     = ctrl.mem_write;
  assign bus.cpuReset     = ctrl.cpu_reset;
  assign bus.busy         = ctrl.busy;
  assign bus.done         = ctrl.done;
  assign bus.error        = ctrl.error;
  assign bus.memAddress   = addr;
  assign bus.memWriteData = word;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a stream-level model predicts the write
// sequence and final outcome; a negedge monitor checks every write cycle.
module tb_prog_loader;

  localparam logic [31:0] TB_BASE = 32'h0000_0000;
  localparam int          TB_MAX  = 256;

  logic clock;
  logic reset;
  prog_loader_if bus ();

  prog_loader #(.BASE_ADDR(TB_BASE), .MAX_WORDS(TB_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stim[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_nwr;
  logic        exp_done;
  logic        exp_err;

  int          wr_seen;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: every write pulse must match the next predicted write.
  always @(negedge clock) begin
    if (reset) begin
      wr_seen = 0;
      log_addr.delete();
      log_data.delete();
    end else begin
      if (bus.memWrite) begin
        log_addr.push_back(bus.memAddress);
        log_data.push_back(bus.memWriteData);
        check("wr_rx_ready_low", 32'(bus.rxReady), 32'd0);
        check("wr_busy_high", 32'(bus.busy), 32'd1);
        if (wr_seen < exp_addr_q.size()) begin
          check("wr_addr", bus.memAddress, exp_addr_q[wr_seen]);
          check("wr_data", bus.memWriteData, exp_data_q[wr_seen]);
        end else begin
          check("wr_unexpected", 32'(bus.memWrite), 32'd0);
        end
        wr_seen++;
      end
      check("cpu_reset_vs_done", 32'(bus.cpuReset), 32'(!bus.done));
    end
  end

  // Stream builders.
  task automatic push_hdr(input int n);
    stim.push_back(8'((n >> 8) & 255));
    stim.push_back(8'(n & 255));
  endtask

  task automatic push_word(input logic [31:0] w);
    stim.push_back(w[31:24]);
    stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);
    stim.push_back(w[7:0]);
  endtask

  task automatic append_csum();
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (stim[i]) x = x ^ stim[i];
      stim.push_back(x);
    end
`endif
  endtask

  // Model: derive expected writes and outcome from the byte stream alone.
  task automatic predict();
    int n;
    exp_addr_q.delete();
    exp_data_q.delete();
    n = (int'(stim[0]) << 8) | int'(stim[1]);
    if (n > TB_MAX) begin
      exp_nwr  = 0;
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(TB_BASE + 32'(4 * i));
      exp_data_q.push_back({stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]});
    end
    exp_nwr  = n;
    exp_done = 1'b1;
    exp_err  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) x = x ^ stim[i];
      if (stim.size() <= 2 + 4 * n || stim[2+4*n] != x) begin
        exp_done = 1'b0;
        exp_err  = 1'b1;
      end
    end
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rxReady), 32'd0);
    check({tag, "_mem_write"}, 32'(bus.memWrite), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_error"}, 32'(bus.error), 32'd0);
    check({tag, "_cpu_reset"}, 32'(bus.cpuReset), 32'd1);
    check({tag, "_mem_addr"}, bus.memAddress, 32'd0);
    check({tag, "_mem_data"}, bus.memWriteData, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxData  = 8'h00;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_nwr = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle("rst");
  endtask

  task automatic pulse_start();
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Send every byte of stim; toggle drops rxValid on alternate cycles.
  task automatic send_stream(input bit toggle);
    int  i;
    int  cycles;
    bit  phase;
    logic rdy;
    i      = 0;
    cycles = 0;
    phase  = 1'b0;
    while (i < stim.size()) begin
      @(negedge clock);
      phase       = toggle ? ~phase : 1'b1;
      rdy         = bus.rxReady;
      bus.rxValid = phase;
      bus.rxData  = phase ? stim[i] : 8'h00;
      @(posedge clock);
      if (phase && rdy) i++;
      cycles++;
      if (cycles > 8 * stim.size() + 50) begin
        check("send_timeout", 32'(i), 32'(stim.size()));
        break;
      end
    end
    @(negedge clock);
    bus.rxValid = 1'b0;
    bus.rxData  = 8'h00;
  endtask

  task automatic wait_outcome();
    int k;
    k = 0;
    while (!(bus.done || bus.error) && k < 40) begin
      @(negedge clock);
      k++;
    end
    check("outcome_reached", 32'(bus.done | bus.error), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
    check({tag, "_error"}, 32'(bus.error), 32'(exp_err));
    check({tag, "_cpu_reset"}, 32'(bus.cpuReset), 32'(!exp_done));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_rx_ready"}, 32'(bus.rxReady), 32'd0);
    check({tag, "_n_writes"}, 32'(wr_seen), 32'(exp_nwr));
  endtask

  task automatic run_load(input string tag, input bit toggle);
    predict();
    pulse_start();
    send_stream(toggle);
    wait_outcome();
    end_checks(tag);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxData  = 8'h00;

    // Single word load.
    do_reset();
    stim.delete();
    push_hdr(1);
    push_word(32'hDEADBEEF);
    append_csum();
    run_load("one_word", 1'b0);
    check("one_word_log_n", 32'(log_data.size()), 32'd1);
    if (log_data.size() >= 1) begin
      check("one_word_lit_addr", log_addr[0], 32'h0000_0000);
      check("one_word_lit_data", log_data[0], 32'hDEADBEEF);
    end
    check("one_word_lit_done", 32'(bus.done), 32'd1);
    check("one_word_lit_cpu_reset", 32'(bus.cpuReset), 32'd0);

    // Start has no effect once finished.
    pulse_start();
    repeat (4) @(negedge clock);
    check("finish_start_done", 32'(bus.done), 32'd1);
    check("finish_start_busy", 32'(bus.busy), 32'd0);
    check("finish_start_nwr", 32'(wr_seen), 32'd1);

    // Three words with gappy rxValid.
    do_reset();
    stim.delete();
    push_hdr(3);
    push_word(32'h01234567);
    push_word(32'h89ABCDEF);
    push_word(32'h0F1E2D3C);
    append_csum();
    run_load("three_toggle", 1'b1);
    check("three_log_n", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      check("three_lit_addr0", log_addr[0], 32'h0000_0000);
      check("three_lit_addr1", log_addr[1], 32'h0000_0004);
      check("three_lit_addr2", log_addr[2], 32'h0000_0008);
      check("three_lit_data2", log_data[2], 32'h0F1E2D3C);
    end

    // Count above MAX_WORDS.
    do_reset();
    stim.delete();
    stim.push_back(8'h01);
    stim.push_back(8'h01);
    run_load("too_long", 1'b0);
    check("too_long_lit_error", 32'(bus.error), 32'd1);
    check("too_long_lit_cpu_reset", 32'(bus.cpuReset), 32'd1);
    pulse_start();
    repeat (4) @(negedge clock);
    check("error_start_error", 32'(bus.error), 32'd1);
    check("error_start_rx_ready", 32'(bus.rxReady), 32'd0);

    // Exactly MAX_WORDS accepted.
    do_reset();
    stim.delete();
    push_hdr(TB_MAX);
    for (int i = 0; i < TB_MAX; i++) begin
      push_word({8'(i), ~8'(i), 8'h5A, 8'(i) ^ 8'hC3});
    end
    append_csum();
    run_load("max_words", 1'b0);
    if (log_addr.size() == TB_MAX) begin
      check("max_lit_last_addr", log_addr[TB_MAX-1], 32'h0000_03FC);
    end else begin
      check("max_log_n", 32'(log_addr.size()), 32'(TB_MAX));
    end

    // Zero-length load.
    do_reset();
    stim.delete();
    push_hdr(0);
    append_csum();
    run_load("zero_len", 1'b0);
    check("zero_lit_nwr", 32'(wr_seen), 32'd0);
    check("zero_lit_done", 32'(bus.done), 32'd1);

    // Reset in the middle of a word, with a byte on offer at the reset edge.
    do_reset();
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h01);
    stim.push_back(8'hDE);
    stim.push_back(8'hAD);
    pulse_start();
    send_stream(1'b0);
    reset       = 1'b1;
    bus.rxValid = 1'b1;
    bus.rxData  = 8'hBE;
    @(negedge clock);
    check_idle("mid_rst");
    reset       = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxData  = 8'h00;
    repeat (3) @(negedge clock);
    check("mid_rst_still_idle", 32'(bus.busy), 32'd0);
    stim.delete();
    push_hdr(1);
    push_word(32'hCAFEBABE);
    append_csum();
    run_load("reload", 1'b0);
    if (log_data.size() == 1) begin
      check("reload_lit_addr", log_addr[0], 32'h0000_0000);
      check("reload_lit_data", log_data[0], 32'hCAFEBABE);
    end else begin
      check("reload_log_n", 32'(log_data.size()), 32'd1);
    end

`ifdef LOADER_CHECKSUM_EN
    // Good and bad checksum bytes.
    do_reset();
    stim.delete();
    push_hdr(1);
    push_word(32'h11223344);
    stim.push_back(8'h45);
    run_load("csum_good", 1'b0);
    check("csum_good_lit_done", 32'(bus.done), 32'd1);

    do_reset();
    stim.delete();
    push_hdr(1);
    push_word(32'h11223344);
    stim.push_back(8'h00);
    run_load("csum_bad", 1'b0);
    check("csum_bad_lit_error", 32'(bus.error), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
